// File: rtl/spi_ram_ctrl.sv
// Command decoder and byte-wide RAM controller behind the SPI slave.
// Decodes 10-bit {opcode, payload} words into pointer loads, RAM writes and RAM reads.
module spi_ram_ctrl #(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam int unsigned AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [7:0]  PTR_MAX = 8'(MEM_DEPTH - 1);
  localparam logic [8:0]  DEPTH9  = 9'(MEM_DEPTH);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } arm_e;

  logic [7:0] mem [MEM_DEPTH];

  arm_e       wr_arm_q, wr_arm_d;
  arm_e       rd_arm_q, rd_arm_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       cmd_err_q, cmd_err_d;

  opcode_e    op;
  logic [7:0] payload;
  logic       payload_ok;
  logic       mem_we;

  function automatic logic [7:0] ptr_inc(input logic [7:0] p);
    return (p == PTR_MAX) ? 8'h00 : p + 8'd1;
  endfunction

  always_comb begin
    op         = opcode_e'(rx_data[9:8]);
    payload    = rx_data[7:0];
    payload_ok = ({1'b0, payload} < DEPTH9);
    wr_arm_d   = wr_arm_q;
    rd_arm_d   = rd_arm_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      unique case (op)
        OP_WR_ADDR: begin
          if (payload_ok) begin
            wr_ptr_d = payload;
            wr_arm_d = ARMED;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_WR_DATA: begin
          if (wr_arm_q == ARMED) begin
            mem_we   = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          if (payload_ok) begin
            rd_ptr_d = payload;
            rd_arm_d = ARMED;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_RD_DATA: begin
          if (rd_arm_q == ARMED) begin
            tx_data_d  = mem[rd_ptr_q[AW-1:0]];
            tx_valid_d = 1'b1;
            rd_ptr_d   = ptr_inc(rd_ptr_q);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM contents survive reset, so the array sits outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= payload;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_arm_q   <= UNARMED;
      rd_arm_q   <= UNARMED;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      wr_arm_q   <= wr_arm_d;
      rd_arm_q   <= rd_arm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: one instance at the default depth, one at depth 16.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       cmd_err_a, cmd_err_b;

  int n_checks = 0;
  int n_errors = 0;

  spi_ram_ctrl dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data_a),
    .rx_valid (rx_valid_a),
    .tx_data  (tx_data_a),
    .tx_valid (tx_valid_a),
    .cmd_err  (cmd_err_a)
  );

  spi_ram_ctrl #(.MEM_DEPTH(16)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data_b),
    .rx_valid (rx_valid_b),
    .tx_data  (tx_data_b),
    .tx_valid (tx_valid_b),
    .cmd_err  (cmd_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks all three outputs of the selected instance at the current time.
  task automatic exp_out(input bit sel, input string tag, input logic v, input logic [7:0] d,
                         input logic e);
    check({tag, ".tx_valid"}, 16'(sel ? tx_valid_b : tx_valid_a), 16'(v));
    check({tag, ".tx_data"},  16'(sel ? tx_data_b  : tx_data_a),  16'(d));
    check({tag, ".cmd_err"},  16'(sel ? cmd_err_b  : cmd_err_a),  16'(e));
  endtask

  // Presents one word for one edge; returns at the negedge where its result is visible.
  task automatic issue(input bit sel, input logic [9:0] w);
    @(negedge clk);
    if (sel) begin
      rx_data_b  = w;
      rx_valid_b = 1'b1;
    end else begin
      rx_data_a  = w;
      rx_valid_a = 1'b1;
    end
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  initial begin
    logic [9:0] seq [4];
    logic       ev  [5];
    logic [7:0] ed  [5];

    rst_n      = 1'b0;
    rx_data_a  = '0;
    rx_data_b  = '0;
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_out(0, "rst_a", 1'b0, 8'h00, 1'b0);
    exp_out(1, "rst_b", 1'b0, 8'h00, 1'b0);

    // Unarmed pointers reject data commands
    issue(0, 10'h155);
    exp_out(0, "unarm_wr", 1'b0, 8'h00, 1'b1);
    issue(0, 10'h300);
    exp_out(0, "unarm_rd", 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    exp_out(0, "unarm_idle", 1'b0, 8'h00, 1'b0);

    // Basic write then read
    issue(0, 10'h010);
    issue(0, 10'h1A5);
    issue(0, 10'h13C);
    issue(0, 10'h210);
    exp_out(0, "basic_rdaddr", 1'b0, 8'h00, 1'b0);
    issue(0, 10'h300);
    exp_out(0, "basic_rd0", 1'b1, 8'hA5, 1'b0);
    issue(0, 10'h300);
    exp_out(0, "basic_rd1", 1'b1, 8'h3C, 1'b0);
    @(negedge clk);
    exp_out(0, "basic_hold", 1'b0, 8'h3C, 1'b0);

    // Read immediately after a write to the same address
    issue(0, 10'h020);
    issue(0, 10'h220);
    @(negedge clk);
    rx_data_a = 10'h15A; rx_valid_a = 1'b1;
    @(negedge clk);
    exp_out(0, "raw_wr", 1'b0, 8'h3C, 1'b0);
    rx_data_a = 10'h300;
    @(negedge clk);
    rx_valid_a = 1'b0;
    exp_out(0, "raw_rd", 1'b1, 8'h5A, 1'b0);

    // Back-to-back read burst
    issue(0, 10'h010);
    issue(0, 10'h101);
    issue(0, 10'h102);
    issue(0, 10'h103);
    seq = '{10'h210, 10'h300, 10'h300, 10'h300};
    ev  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ed  = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h03};
    @(negedge clk);
    rx_data_a = seq[0]; rx_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) rx_data_a = seq[i+1];
      else rx_valid_a = 1'b0;
      exp_out(0, $sformatf("b2b%0d", i), ev[i], ed[i], 1'b0);
    end

    // Wrap at depth 16
    issue(1, 10'h00F);
    issue(1, 10'h111);
    issue(1, 10'h122);
    issue(1, 10'h200);
    issue(1, 10'h300);
    exp_out(1, "wrap_rd0", 1'b1, 8'h22, 1'b0);
    issue(1, 10'h20F);
    issue(1, 10'h300);
    exp_out(1, "wrap_rdF", 1'b1, 8'h11, 1'b0);
    issue(1, 10'h300);
    exp_out(1, "wrap_rd10", 1'b1, 8'h22, 1'b0);

    // Out-of-range addresses keep the previous pointer
    issue(1, 10'h003);
    exp_out(1, "oor_wa3", 1'b0, 8'h22, 1'b0);
    issue(1, 10'h020);
    exp_out(1, "oor_wa20", 1'b0, 8'h22, 1'b1);
    issue(1, 10'h177);
    exp_out(1, "oor_wd", 1'b0, 8'h22, 1'b0);
    issue(1, 10'h203);
    issue(1, 10'h210);
    exp_out(1, "oor_ra10", 1'b0, 8'h22, 1'b1);
    issue(1, 10'h300);
    exp_out(1, "oor_rd", 1'b1, 8'h77, 1'b0);

    // Reset while a read is in flight
    issue(0, 10'h005);
    issue(0, 10'h1C3);
    issue(0, 10'h205);
    @(negedge clk);
    rx_data_a = 10'h300; rx_valid_a = 1'b1;
    #2 rst_n = 1'b0;
    #4 exp_out(0, "rstmid_edge", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rx_valid_a = 1'b0;
    exp_out(0, "rstmid_hold", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 10'h300);
    exp_out(0, "post_rst_rd", 1'b0, 8'h00, 1'b1);
    issue(0, 10'h205);
    issue(0, 10'h300);
    exp_out(0, "post_rst_ram", 1'b1, 8'hC3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
